// File: rtl/zintack.sv
// Z80 interrupt-acknowledge handler: detects IM2 acknowledge cycles, drives the vector,
// and (with ZINTACK_RETI_EN defined) decodes RETI fetches to track ISR nesting depth.
module zintack (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic [7:0] din,
    input  logic [7:0] im2vect,
    output logic       intack,
    output logic [7:0] dout,
    output logic       dout_oe,
    output logic       reti,
    output logic       in_isr
);

    logic       m1_q;
    logic       iorq_q;
    logic       in_vld_q;
    logic       armed_q;
    logic       armed_d;
    logic       intack_q;
    logic       intack_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [7:0] dout_q;
    logic [7:0] dout_d;
    logic       ack_cond;
    logic       intack_rise;
    logic       intack_fall;

    assign ack_cond    = !m1_q && !iorq_q;
    assign intack_d    = intack_q ? ack_cond : (ack_cond && armed_q);
    assign intack_rise = intack_d && !intack_q;
    assign intack_fall = intack_q && !intack_d;

    // The idle values forced into the input registers by reset are not real bus
    // observations, so they must not arm; otherwise an acknowledge held across
    // reset would re-trigger without the bus ever going idle.
    always_comb begin
        armed_d = armed_q;
        if (!ack_cond && in_vld_q)
            armed_d = 1'b1;
        else if (intack_rise)
            armed_d = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!intack_q)
            cnt_d = 3'd0;
        else if (cnt_q != 3'd3)
            cnt_d = cnt_q + 3'd1;
    end

    assign dout_d = (intack_q && cnt_q == 3'd2) ? im2vect : dout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m1_q     <= 1'b1;
            iorq_q   <= 1'b1;
            in_vld_q <= 1'b0;
            armed_q  <= 1'b0;
            intack_q <= 1'b0;
            cnt_q    <= 3'd0;
            dout_q   <= 8'hFF;
        end else begin
            m1_q     <= m1_n;
            iorq_q   <= iorq_n;
            in_vld_q <= 1'b1;
            armed_q  <= armed_d;
            intack_q <= intack_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    assign intack  = intack_q;
    assign dout    = dout_q;
    assign dout_oe = intack_q && (cnt_q == 3'd3);

`ifdef ZINTACK_RETI_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_GOT_ED = 1'b1;

    logic       mreq_q;
    logic       rd_q;
    logic [7:0] din_q;
    logic       fetch_cond;
    logic       fetch_q;
    logic       fetch_end;
    logic [7:0] op_q;
    logic [7:0] op_d;
    logic [0:0] st_q;
    logic [0:0] st_d;
    logic       reti_q;
    logic       reti_d;
    logic [2:0] depth_q;
    logic [2:0] depth_d;
    logic       in_isr_q;

    assign fetch_cond = !m1_q && !mreq_q && !rd_q;
    assign fetch_end  = fetch_q && !fetch_cond;
    // Opcode is the data seen on the last clk of the fetch.
    assign op_d       = fetch_cond ? din_q : op_q;

    always_comb begin
        st_d   = st_q;
        reti_d = 1'b0;
        if (intack_rise) begin
            st_d = ST_IDLE;
        end else if (fetch_end) begin
            case (st_q)
                ST_IDLE:   st_d = (op_q == 8'hED) ? ST_GOT_ED : ST_IDLE;
                ST_GOT_ED: begin
                    if (op_q == 8'h4D) begin
                        reti_d = 1'b1;
                        st_d   = ST_IDLE;
                    end else if (op_q == 8'hED) begin
                        st_d = ST_GOT_ED;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
                default:   st_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        depth_d = depth_q;
        case ({intack_fall, reti_q})
            2'b10:   if (depth_q != 3'd7) depth_d = depth_q + 3'd1;
            2'b01:   if (depth_q != 3'd0) depth_d = depth_q - 3'd1;
            default: depth_d = depth_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mreq_q   <= 1'b1;
            rd_q     <= 1'b1;
            din_q    <= 8'hFF;
            fetch_q  <= 1'b0;
            op_q     <= 8'h00;
            st_q     <= ST_IDLE;
            reti_q   <= 1'b0;
            depth_q  <= 3'd0;
            in_isr_q <= 1'b0;
        end else begin
            mreq_q   <= mreq_n;
            rd_q     <= rd_n;
            din_q    <= din;
            fetch_q  <= fetch_cond;
            op_q     <= op_d;
            st_q     <= st_d;
            reti_q   <= reti_d;
            depth_q  <= depth_d;
            in_isr_q <= (depth_d != 3'd0);
        end
    end

    assign reti   = reti_q;
    assign in_isr = in_isr_q;
`else
    logic unused_fetch;
    assign unused_fetch = ^{din, mreq_n, rd_n, intack_fall};
    assign reti   = 1'b0;
    assign in_isr = 1'b0;
`endif

endmodule

// File: tb/tb_zintack.sv
// Randomized self-checking bench for zintack; expectations come from a transaction-level
// model (saturating depth count, pending-ED flag, last captured vector).
module tb_zintack;

`ifdef ZINTACK_RETI_EN
    localparam bit RETI_EN = 1'b1;
`else
    localparam bit RETI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m1_n = 1'b1;
    logic       iorq_n = 1'b1;
    logic       mreq_n = 1'b1;
    logic       rd_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] im2vect = 8'h00;
    logic       intack;
    logic [7:0] dout;
    logic       dout_oe;
    logic       reti;
    logic       in_isr;

    int         n_chk = 0;
    int         n_err = 0;
    int         depth = 0;
    bit         pend_ed = 1'b0;
    logic [7:0] exp_dout = 8'hFF;

    zintack dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m1_n    (m1_n),
        .iorq_n  (iorq_n),
        .mreq_n  (mreq_n),
        .rd_n    (rd_n),
        .din     (din),
        .im2vect (im2vect),
        .intack  (intack),
        .dout    (dout),
        .dout_oe (dout_oe),
        .reti    (reti),
        .in_isr  (in_isr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit isr_exp(input int d);
        return RETI_EN && (d != 0);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_intack", intack, 0);
            chk("idle_oe", dout_oe, 0);
            chk("idle_reti", reti, 0);
            chk("idle_in_isr", in_isr, isr_exp(depth));
            chk("idle_dout", dout, exp_dout);
        end
    endtask

    // Acknowledge with bus held active for L clks; the vector is valid only on the clk it is captured.
    task automatic do_ack(input int L, input logic [7:0] vec);
        int dn;
        dn = (depth < 7) ? depth + 1 : 7;
        m1_n = 1'b0; iorq_n = 1'b0; im2vect = 8'($urandom);
        for (int c = 1; c <= L + 2; c++) begin
            step();
            if (c == L) begin m1_n = 1'b1; iorq_n = 1'b1; end
            im2vect = (c == 4) ? vec : 8'($urandom);
            chk("ack_intack", intack, (c >= 2 && c <= L + 1));
            chk("ack_oe", dout_oe, (c >= 5 && c <= L + 1));
            if (c >= 5) chk("ack_dout", dout, vec);
            chk("ack_reti", reti, 0);
            chk("ack_in_isr", in_isr, isr_exp(c >= L + 2 ? dn : depth));
        end
        depth = dn; pend_ed = 1'b0; exp_dout = vec;
    endtask

    task automatic do_fetch(input logic [7:0] b);
        bit done;
        int dn;
        done = pend_ed && (b == 8'h4D);
        dn   = (done && depth > 0) ? depth - 1 : depth;
        m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; din = b;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 2) begin m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; end
            if (c == 3) din = 8'($urandom);
            chk("fetch_reti", reti, RETI_EN && done && (c == 4));
            chk("fetch_in_isr", in_isr, isr_exp(c >= 5 ? dn : depth));
            chk("fetch_intack", intack, 0);
            chk("fetch_dout", dout, exp_dout);
        end
        depth = dn; pend_ed = (b == 8'hED);
    endtask

    task automatic ack_reset(input logic [7:0] vec);
        m1_n = 1'b0; iorq_n = 1'b0; im2vect = 8'($urandom);
        for (int c = 1; c <= 6; c++) begin
            step();
            im2vect = (c == 4) ? vec : 8'($urandom);
            chk("rst_ack_intack", intack, c >= 2);
            chk("rst_ack_oe", dout_oe, c >= 5);
        end
        rst_n = 1'b0;
        step();
        chk("rst_mid_intack", intack, 0);
        chk("rst_mid_oe", dout_oe, 0);
        chk("rst_mid_dout", dout, 8'hFF);
        chk("rst_mid_in_isr", in_isr, 0);
        rst_n = 1'b1;
        depth = 0; pend_ed = 1'b0; exp_dout = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_noreassert", intack, 0);
            chk("rst_noreassert_oe", dout_oe, 0);
        end
        m1_n = 1'b1; iorq_n = 1'b1;
        idle(3);
    endtask

    initial begin
        logic [7:0] tbl [4];
        tbl[0] = 8'hED; tbl[1] = 8'h4D; tbl[2] = 8'h00; tbl[3] = 8'h5A;

        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_intack", intack, 0);
        chk("rst_dout", dout, 8'hFF);
        chk("rst_oe", dout_oe, 0);
        chk("rst_reti", reti, 0);
        chk("rst_in_isr", in_isr, 0);
        rst_n = 1'b1;
        idle(3);

        do_ack(12, 8'hFD);
        idle(2);
        do_fetch(8'hED); do_fetch(8'h4D);
        idle(1);

        do_ack(5, 8'($urandom)); idle(1);
        do_fetch(8'hED); do_fetch(8'hED); do_fetch(8'h4D);
        do_fetch(8'hED); do_fetch(8'h00); do_fetch(8'h4D);
        do_fetch(8'hED); idle(1); do_ack(6, 8'($urandom)); idle(1); do_fetch(8'h4D);
        idle(1);

        for (int i = 0; i < 8; i++) begin
            do_ack(int'($urandom_range(5, 10)), 8'($urandom));
            idle(1);
        end
        chk("depth_sat_isr", in_isr, RETI_EN);
        for (int i = 0; i < 9; i++) begin
            do_fetch(8'hED); do_fetch(8'h4D);
        end
        idle(1);
        chk("depth_zero_isr", in_isr, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_ack(int'($urandom_range(4, 14)), 8'($urandom));
                idle(1);
            end else begin
                do_fetch(tbl[$urandom_range(0, 3)]);
            end
        end
        idle(1);

        do_ack(8, 8'($urandom)); idle(1);
        ack_reset(8'($urandom));
        do_ack(6, 8'($urandom));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
